// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, operation codes, state encodings and access-size helpers
// for the byte-serial MEM-stage controller.
package mem_access_ctrl_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [ALU_OP_W-1:0]   alu_op_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
  typedef logic [REG_W-1:0]      reg_bus_t;

  localparam alu_op_bus_t EXE_NOP_OP = 8'b0000_0000;
  localparam alu_op_bus_t EXE_ADD_OP = 8'b0010_0000;
  localparam alu_op_bus_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_bus_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_bus_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_bus_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_bus_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_bus_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_bus_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_bus_t EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE   = 2'b00,
    MEM_STATE_ACCESS = 2'b01,
    MEM_STATE_DONE   = 2'b10
  } mem_state_e;

  localparam logic [2:0] MEM_SIZE_NONE = 3'd0;
  localparam logic [2:0] MEM_SIZE_B    = 3'd1;
  localparam logic [2:0] MEM_SIZE_H    = 3'd2;
  localparam logic [2:0] MEM_SIZE_W    = 3'd4;

  // Zero size marks a non-memory (or unknown) operation.
  function automatic logic [2:0] mem_size(input alu_op_bus_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: mem_size = MEM_SIZE_B;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: mem_size = MEM_SIZE_H;
      EXE_LW_OP, EXE_SW_OP:             mem_size = MEM_SIZE_W;
      default:                          mem_size = MEM_SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input alu_op_bus_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: op_is_load = 1'b1;
      default:                                                op_is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Sign/zero extension of an assembled little-endian load value to 32 bits.
module mem_load_ext
  import mem_access_ctrl_pkg::*;
(
  input  alu_op_bus_t aluop,
  input  reg_bus_t    raw,
  output reg_bus_t    ext
);

  always_comb begin
    ext = raw;
    case (aluop)
      EXE_LB_OP:  ext = {{24{raw[7]}}, raw[7:0]};
      EXE_LBU_OP: ext = {24'h0, raw[7:0]};
      EXE_LH_OP:  ext = {{16{raw[15]}}, raw[15:0]};
      EXE_LHU_OP: ext = {16'h0, raw[15:0]};
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: serialises loads/stores over an 8-bit RAM port and
// stalls the pipeline until the access completes.
//   state  | meaning
//   IDLE   | accept op; pass non-memory ops through, issue byte 0 of memory ops
//   ACCESS | issue/capture remaining bytes, cnt_q = byte index
//   DONE   | present load result, release stall, return to IDLE
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  alu_op_bus_t               aluop_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               reg2_i,
  input  reg_addr_bus_t             wd_i,
  input  logic                      wreg_i,
  input  logic [31:0]               wdata_i,
  input  logic [7:0]                mem_din_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a_o,
  output logic                      mem_wr_o,
  output logic [7:0]                mem_dout_o,
  output reg_addr_bus_t             wd_o,
  output logic                      wreg_o,
  output logic [31:0]               wdata_o,
  output logic                      stallreq_o
);

  if (RD_LATENCY != 1) begin : g_bad_rd_latency
    $error("mem_access_ctrl: only RD_LATENCY == 1 is supported");
  end

  mem_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  reg_bus_t    asm_q, asm_d;
  logic [2:0]  size;
  logic        is_mem, is_load;
  logic [31:0] addr_off, addr_sel;
  reg_bus_t    load_ext;

  assign size     = mem_size(aluop_i);
  assign is_mem   = (size != MEM_SIZE_NONE);
  assign is_load  = op_is_load(aluop_i);
  assign addr_off = mem_addr_i + {29'h0, cnt_q};
  assign mem_a_o  = addr_sel[MEM_ADDR_WIDTH-1:0];

  mem_load_ext u_load_ext (
    .aluop (aluop_i),
    .raw   (asm_q),
    .ext   (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_STATE_IDLE;
      cnt_q   <= 3'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    addr_sel   = '0;
    mem_wr_o   = 1'b0;
    mem_dout_o = '0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;

    case (state_q)
      MEM_STATE_IDLE: begin
        if (!is_mem) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end else if (is_load) begin
          addr_sel   = mem_addr_i;
          stallreq_o = 1'b1;
          asm_d      = '0;
          cnt_d      = 3'd1;
          state_d    = MEM_STATE_ACCESS;
        end else begin
          addr_sel   = mem_addr_i;
          mem_wr_o   = 1'b1;
          mem_dout_o = reg2_i[7:0];
          stallreq_o = 1'b1;
          cnt_d      = 3'd1;
          state_d    = (size == MEM_SIZE_B) ? MEM_STATE_DONE : MEM_STATE_ACCESS;
        end
      end

      MEM_STATE_ACCESS: begin
        stallreq_o = 1'b1;
        if (!is_mem) begin
          state_d = MEM_STATE_IDLE;
        end else if (is_load) begin
          // Byte cnt-1 arrives one cycle after its address was driven.
          case (cnt_q)
            3'd1:    asm_d[7:0]   = mem_din_i;
            3'd2:    asm_d[15:8]  = mem_din_i;
            3'd3:    asm_d[23:16] = mem_din_i;
            3'd4:    asm_d[31:24] = mem_din_i;
            default: asm_d        = asm_q;
          endcase
          if (cnt_q < size) begin
            addr_sel = addr_off;
            cnt_d    = cnt_q + 3'd1;
          end else begin
            state_d = MEM_STATE_DONE;
          end
        end else begin
          addr_sel   = addr_off;
          mem_wr_o   = 1'b1;
          mem_dout_o = reg2_i[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == size - 3'd1) begin
            state_d = MEM_STATE_DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      MEM_STATE_DONE: begin
        state_d = MEM_STATE_IDLE;
        cnt_d   = 3'd0;
        if (is_load) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = load_ext;
        end
      end

      default: begin
        state_d = MEM_STATE_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (rst) begin
      addr_sel   = '0;
      mem_wr_o   = 1'b0;
      mem_dout_o = '0;
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a byte RAM model answers the port,
// and each op is checked against size/extension rules computed here.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  alu_op_bus_t   aluop_i;
  logic [31:0]   mem_addr_i, reg2_i, wdata_i;
  reg_addr_bus_t wd_i;
  logic          wreg_i;
  logic [7:0]    mem_din_i;
  logic [31:0]   mem_a_o;
  logic          mem_wr_o;
  logic [7:0]    mem_dout_o;
  reg_addr_bus_t wd_o;
  logic          wreg_o;
  logic [31:0]   wdata_o;
  logic          stallreq_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] pend_a = 32'h0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_ADDR_WIDTH(32), .RD_LATENCY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .mem_din_i  (mem_din_i),
    .mem_a_o    (mem_a_o),
    .mem_wr_o   (mem_wr_o),
    .mem_dout_o (mem_dout_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Advance to 1ns after the next rising edge and present last cycle's read byte.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_din_i = ram_rd(pend_a);
  endtask

  task automatic observe_mem();
    pend_a = mem_a_o;
    if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
  endtask

  function automatic int op_bytes(input alu_op_bus_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_load(input alu_op_bus_t op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic [31:0] ref_load(input alu_op_bus_t op, input logic [31:0] addr);
    longint unsigned v;
    longint unsigned half;
    int n;
    n = op_bytes(op);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ram_rd(addr + 32'(i))) << (8 * i));
    half = longint'(1) << (8 * n - 1);
    if (((op == EXE_LB_OP) || (op == EXE_LH_OP)) && (v >= half))
      v = v + (longint'(1) << 32) - (half * 2);
    return v[31:0];
  endfunction

  // Called 1ns after a rising edge; returns 1ns after the edge following the op's last cycle.
  task automatic run_op(input alu_op_bus_t op, input logic [31:0] addr, input logic [31:0] data,
                        input reg_addr_bus_t wd, input logic wreg, input logic [31:0] wdata,
                        output logic [31:0] got);
    int n, exp_stall, stalls, cyc;
    bit ld, st, done, wreg_in_stall;
    logic [31:0] exp_val;
    n         = op_bytes(op);
    ld        = op_load(op);
    st        = (n > 0) && !ld;
    exp_stall = ld ? n + 1 : (st ? n : 0);
    exp_val   = ld ? ref_load(op, addr) : 32'h0;
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = data;
    wd_i       = wd;
    wreg_i     = wreg;
    wdata_i    = wdata;
    stalls = 0; cyc = 0; done = 0; wreg_in_stall = 0; got = '0;
    while (!done && cyc < 12) begin
      #1;
      if (stallreq_o) begin
        stalls++;
        if (wreg_o) wreg_in_stall = 1;
        if (ld && cyc < n) begin
          check_val("ld_addr", mem_a_o, addr + 32'(cyc));
          check_val("ld_nowr", 32'(mem_wr_o), 32'h0);
        end
        if (st && cyc < n) begin
          check_val("st_wr", 32'(mem_wr_o), 32'h1);
          check_val("st_addr", mem_a_o, addr + 32'(cyc));
          check_val("st_data", 32'(mem_dout_o), (data >> (8 * cyc)) & 32'hFF);
        end
      end else begin
        done = 1;
        got  = wdata_o;
        check_val("done_wr", 32'(mem_wr_o), 32'h0);
        if (ld) begin
          check_val("ld_data", wdata_o, exp_val);
          check_val("ld_wreg", 32'(wreg_o), 32'(wreg));
          check_val("ld_wd", 32'(wd_o), 32'(wd));
        end else if (st) begin
          check_val("st_wreg", 32'(wreg_o), 32'h0);
          check_val("st_wdata", wdata_o, 32'h0);
        end else begin
          check_val("pass_data", wdata_o, wdata);
          check_val("pass_wreg", 32'(wreg_o), 32'(wreg));
          check_val("pass_wd", 32'(wd_o), 32'(wd));
          check_val("pass_addr", mem_a_o, 32'h0);
        end
      end
      observe_mem();
      tick();
      cyc++;
    end
    check_val("op_done", 32'(done), 32'h1);
    check_val("stall_cnt", 32'(stalls), 32'(exp_stall));
    check_val("stall_wreg", 32'(wreg_in_stall), 32'h0);
  endtask

  alu_op_bus_t ops [10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP, 8'hFF};

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int sel;

    rst = 1'b1;
    aluop_i = EXE_ADD_OP; mem_addr_i = 32'h100; reg2_i = 32'hDEAD_BEEF;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h5; mem_din_i = 8'h0;
    @(posedge clk); #1;
    #1;
    check_val("rst_stall", 32'(stallreq_o), 32'h0);
    check_val("rst_wr", 32'(mem_wr_o), 32'h0);
    check_val("rst_addr", mem_a_o, 32'h0);
    check_val("rst_wreg", 32'(wreg_o), 32'h0);
    check_val("rst_wdata", wdata_o, 32'h0);
    check_val("rst_wd", 32'(wd_o), 32'h0);
    tick();
    rst = 1'b0;

    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    run_op(EXE_LW_OP, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0, got);
    check_val("tp_lw", got, 32'h1234_5678);

    ram[32'h40] = 8'h80;
    run_op(EXE_LB_OP, 32'h40, 32'h0, 5'd2, 1'b1, 32'h0, got);
    check_val("tp_lb", got, 32'hFFFF_FF80);
    run_op(EXE_LBU_OP, 32'h40, 32'h0, 5'd2, 1'b1, 32'h0, got);
    check_val("tp_lbu", got, 32'h0000_0080);

    ram[32'h101] = 8'hFE; ram[32'h102] = 8'hFF;
    run_op(EXE_LHU_OP, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, got);
    check_val("tp_lhu", got, 32'h0000_FFFE);
    run_op(EXE_LH_OP, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, got);
    check_val("tp_lh", got, 32'hFFFF_FFFE);

    run_op(EXE_SH_OP, 32'h200, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h0, got);
    check_val("tp_sh_b0", 32'(ram_rd(32'h200)), 32'hDD);
    check_val("tp_sh_b1", 32'(ram_rd(32'h201)), 32'hCC);

    run_op(EXE_LW_OP, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0, got);
    run_op(EXE_ADD_OP, 32'h0, 32'h0, 5'd7, 1'b1, 32'h5, got);
    check_val("tp_add", got, 32'h5);
    run_op(EXE_SW_OP, 32'h300, 32'h0102_0304, 5'd0, 1'b0, 32'h0, got);
    run_op(EXE_LW_OP, 32'h300, 32'h0, 5'd8, 1'b1, 32'h0, got);
    check_val("tp_lw_sw", got, 32'h0102_0304);
    run_op(EXE_SW_OP, 32'h310, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, got);
    run_op(EXE_LW_OP, 32'h310, 32'h0, 5'd9, 1'b1, 32'h0, got);
    check_val("tp_sw_back", got, 32'hCAFE_F00D);

    // Reset during the third cycle of a word load.
    ram[32'h500] = 8'h11; ram[32'h501] = 8'h22; ram[32'h502] = 8'h33; ram[32'h503] = 8'h44;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h500; wd_i = 5'd10; wreg_i = 1'b1; wdata_i = 32'h0;
    #1; observe_mem(); tick();
    #1; observe_mem(); tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_stall", 32'(stallreq_o), 32'h0);
    check_val("mid_rst_addr", mem_a_o, 32'h0);
    check_val("mid_rst_wreg", 32'(wreg_o), 32'h0);
    check_val("mid_rst_wdata", wdata_o, 32'h0);
    observe_mem(); tick();
    rst = 1'b0;
    aluop_i = EXE_NOP_OP; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    #1;
    check_val("post_rst_stall", 32'(stallreq_o), 32'h0);
    check_val("post_rst_wr", 32'(mem_wr_o), 32'h0);
    check_val("post_rst_wdata", wdata_o, 32'h0);
    observe_mem(); tick();
    run_op(EXE_LW_OP, 32'h500, 32'h0, 5'd10, 1'b1, 32'h0, got);
    check_val("post_rst_lw", got, 32'h4433_2211);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0, 1:    a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2:       a = $urandom;
        default: a = 32'h0000_0600 + 32'($urandom_range(0, 31));
      endcase
      run_op(ops[sel], a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
